// File: rtl/audio_codec_link.sv
`default_nettype none
// ============================================================================
// Module   : audio_codec_link
// Purpose  : I2S link to an audio codec. Generates the bit clock and word
//            selects, serialises one 16-bit DAC sample per frame into both
//            channel slots, and deserialises the left ADC slot.
//            Optional feature macro: AUDIO_LOOPBACK_EN (adds the loopback
//            port that routes the outgoing DAC bit into the rx path).
// Revision : 1.0 - initial release
// ============================================================================
module audio_codec_link #(
    parameter int unsigned BCLK_HALF = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] audio_output,
    output logic [15:0] audio_input,
    output logic        sample_req,
    output logic        sample_end,
    output logic        AUD_BCLK,
    output logic        AUD_DACLRCK,
    output logic        AUD_ADCLRCK,
    output logic        AUD_DACDAT,
    input  logic        AUD_ADCDAT
`ifdef AUDIO_LOOPBACK_EN
    ,
    input  logic        loopback
`endif
);

    localparam logic [7:0] c_div_last = 8'(BCLK_HALF - 1);

    logic [7:0]  r_div;
    logic        r_bclk;
    logic [5:0]  r_bitcnt;
    logic [15:0] r_tx;
    logic [15:0] r_rx;
    logic        r_dacdat;
    logic        r_sample_req;
    logic        r_rx_done;
    logic        r_sample_end;
    logic [15:0] r_audio_input;

    logic        w_wrap;
    logic        w_fall;
    logic        w_rise;
    logic [5:0]  w_next_bit;
    logic [4:0]  w_next_off;
    logic [3:0]  w_tx_sel;
    logic        w_dac_next;
    logic        w_rx_shift;
    logic        w_rx_bit;

    // Edge strobes: the divider wrap toggles BCLK, so the current BCLK level
    // tells whether the coming toggle is a rising or a falling edge.
    assign w_wrap = (r_div == c_div_last);
    assign w_fall = w_wrap & r_bclk;
    assign w_rise = w_wrap & ~r_bclk;

`ifdef AUDIO_LOOPBACK_EN
    assign w_rx_bit = loopback ? r_dacdat : AUD_ADCDAT;
`else
    assign w_rx_bit = AUD_ADCDAT;
`endif

    // Next slot position and the DAC bit to present once BCLK falls into it
    always_comb begin
        w_next_bit = r_bitcnt + 6'd1;
        w_next_off = w_next_bit[4:0];
        w_tx_sel   = 4'(5'd16 - w_next_off);
        w_dac_next = 1'b0;
        if ((w_next_off >= 5'd1) && (w_next_off <= 5'd16)) begin
            w_dac_next = r_tx[w_tx_sel];
        end
        w_rx_shift = w_rise && !r_bitcnt[5] &&
                     (r_bitcnt[4:0] >= 5'd1) && (r_bitcnt[4:0] <= 5'd16);
    end

    // Bit-clock divider
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div  <= 8'd0;
            r_bclk <= 1'b0;
        end else if (w_wrap) begin
            r_div  <= 8'd0;
            r_bclk <= ~r_bclk;
        end else begin
            r_div  <= r_div + 8'd1;
        end
    end

    // Transmit side: slot counter, sample latch, DAC bit and request pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bitcnt     <= 6'd0;
            r_tx         <= 16'd0;
            r_dacdat     <= 1'b0;
            r_sample_req <= 1'b0;
        end else begin
            r_sample_req <= w_fall && (w_next_bit == 6'd63);
            if (w_fall) begin
                r_bitcnt <= w_next_bit;
                r_dacdat <= w_dac_next;
                // Latched only at frame start so both slots carry one sample
                if (w_next_bit == 6'd0) begin
                    r_tx <= audio_output;
                end
            end
        end
    end

    // Receive side: left-slot shift register and the publish stage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx          <= 16'd0;
            r_rx_done     <= 1'b0;
            r_sample_end  <= 1'b0;
            r_audio_input <= 16'd0;
        end else begin
            if (w_rx_shift) begin
                r_rx <= {r_rx[14:0], w_rx_bit};
            end
            r_rx_done    <= w_rise && (r_bitcnt == 6'd16);
            r_sample_end <= r_rx_done;
            if (r_rx_done) begin
                r_audio_input <= r_rx;
            end
        end
    end

    assign AUD_BCLK    = r_bclk;
    assign AUD_DACLRCK = r_bitcnt[5];
    assign AUD_ADCLRCK = r_bitcnt[5];
    assign AUD_DACDAT  = r_dacdat;
    assign sample_req  = r_sample_req;
    assign sample_end  = r_sample_end;
    assign audio_input = r_audio_input;

endmodule
`default_nettype wire

// File: tb/tb_audio_codec_link.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_codec_link
// Purpose  : Scoreboard bench for audio_codec_link. Stimulus queues the
//            expected DAC word per frame and the expected ADC capture; a
//            monitor/codec model tracks BCLK, serves ADC bits, and checks
//            outputs as they appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_codec_link;

    localparam int BCLK_HALF = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] audio_output = 16'h0000;
    logic [15:0] audio_input;
    logic        sample_req;
    logic        sample_end;
    logic        AUD_BCLK;
    logic        AUD_DACLRCK;
    logic        AUD_ADCLRCK;
    logic        AUD_DACDAT;
    logic        AUD_ADCDAT = 1'b0;
`ifdef AUDIO_LOOPBACK_EN
    logic        loopback = 1'b0;
`endif

    audio_codec_link #(.BCLK_HALF(BCLK_HALF)) dut (
        .clk          (clk),
        .reset        (reset),
        .audio_output (audio_output),
        .audio_input  (audio_input),
        .sample_req   (sample_req),
        .sample_end   (sample_end),
        .AUD_BCLK     (AUD_BCLK),
        .AUD_DACLRCK  (AUD_DACLRCK),
        .AUD_ADCLRCK  (AUD_ADCLRCK),
        .AUD_DACDAT   (AUD_DACDAT),
        .AUD_ADCDAT   (AUD_ADCDAT)
`ifdef AUDIO_LOOPBACK_EN
        ,
        .loopback     (loopback)
`endif
    );

    always #5 clk = ~clk;

    // Reset as seen by the DUT at its last rising edge
    logic rst_q = 1'b1;
    always @(posedge clk) rst_q <= reset;

    int total  = 0;
    int passed = 0;

    logic [15:0] exp_tx[$];
    logic [15:0] exp_rx[$];

    logic [15:0] adc_l [5] = '{16'h8001, 16'h0000, 16'h5A3C, 16'hFFFE, 16'h7FFF};
    logic [15:0] adc_r [5] = '{16'hFFFF, 16'hFFFF, 16'h1111, 16'h0001, 16'h8000};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    endtask

    function automatic logic adc_bit(input int b, input logic [15:0] l, input logic [15:0] r);
        int o;
        logic [15:0] w;
        o = b % 32;
        w = (b < 32) ? l : r;
        if (o >= 1 && o <= 16) return w[16-o];
        // Non-zero junk around the left sample catches slot misalignment
        if (b < 32 && (o == 0 || o == 17)) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- monitor + codec model ----------------
    int          cyc = 0;
    int          tb_bit = 0;
    logic        bclk_q = 1'b0;
    logic        was_rst = 1'b0;
    int          rel_cyc = 0;
    logic        first_req_pending = 1'b0;
    int          last_rise = 0;
    logic        have_rise = 1'b0;
    logic [63:0] dac_bits = '0;
    int          ends = 0;
    int          reqs = 0;
    int          tbl = 0;
    logic [15:0] cur_l = 16'h0;
    logic [15:0] cur_r = 16'h0;
    logic        lb_frame = 1'b0;

    task automatic start_frame();
        cur_l = adc_l[tbl];
        cur_r = adc_r[tbl];
        tbl = (tbl + 1) % 5;
        lb_frame = 1'b0;
`ifdef AUDIO_LOOPBACK_EN
        lb_frame = loopback;
`endif
        if (lb_frame) begin
            if (exp_tx.size() > 0) exp_rx.push_back(exp_tx[0]);
        end else begin
            exp_rx.push_back(cur_l);
        end
        dac_bits = '0;
        ends = 0;
        reqs = 0;
    endtask

    task automatic end_frame();
        logic [15:0] lw, rw, want;
        logic [63:0] others;
        lw = '0;
        rw = '0;
        others = dac_bits;
        for (int o = 1; o <= 16; o++) begin
            lw = {lw[14:0], dac_bits[o]};
            rw = {rw[14:0], dac_bits[32+o]};
            others[o] = 1'b0;
            others[32+o] = 1'b0;
        end
        if (exp_tx.size() == 0) begin
            check("tx_queue_nonempty", 32'd0, 32'd1);
        end else begin
            want = exp_tx.pop_front();
            check("tx_left_word", {16'h0, lw}, {16'h0, want});
            check("tx_right_word", {16'h0, rw}, {16'h0, want});
            check("tx_pad_bits_zero", {31'h0, |others}, 32'd0);
        end
        check("sample_end_per_frame", ends, 1);
        check("sample_req_per_frame", reqs, 1);
    endtask

    initial begin
        forever begin
            logic rise, fall;
            @(negedge clk);
            cyc++;
            if (rst_q) begin
                check("outputs_in_reset",
                      {15'h0, audio_input, sample_req, sample_end, AUD_BCLK,
                       AUD_DACLRCK, AUD_ADCLRCK, AUD_DACDAT}, 32'd0);
                tb_bit = 0;
                bclk_q = 1'b0;
                have_rise = 1'b0;
                exp_tx.delete();
                exp_tx.push_back(16'h0000);
                exp_rx.delete();
                AUD_ADCDAT = 1'b0;
                was_rst = 1'b1;
            end else begin
                if (was_rst) begin
                    was_rst = 1'b0;
                    rel_cyc = cyc;
                    first_req_pending = 1'b1;
                    check("audio_input_after_reset", {16'h0, audio_input}, 32'd0);
                    start_frame();
                    AUD_ADCDAT = lb_frame ? 1'b0 : adc_bit(0, cur_l, cur_r);
                end
                rise = AUD_BCLK && !bclk_q;
                fall = !AUD_BCLK && bclk_q;
                bclk_q = AUD_BCLK;
                if (fall) begin
                    if (tb_bit == 63) begin
                        end_frame();
                        tb_bit = 0;
                        start_frame();
                    end else begin
                        tb_bit++;
                    end
                    AUD_ADCDAT = lb_frame ? 1'b0 : adc_bit(tb_bit, cur_l, cur_r);
                end
                if (rise) begin
                    dac_bits[tb_bit] = AUD_DACDAT;
                    if (tb_bit == 0 || tb_bit == 31 || tb_bit == 32 || tb_bit == 63) begin
                        check("dac_lrck", {31'h0, AUD_DACLRCK}, {31'h0, tb_bit >= 32});
                        check("adc_lrck_eq_dac", {31'h0, AUD_ADCLRCK}, {31'h0, AUD_DACLRCK});
                    end
                    if ((tb_bit == 0 || tb_bit == 32) && have_rise)
                        check("bclk_period", cyc - last_rise, 2 * BCLK_HALF);
                    last_rise = cyc;
                    have_rise = 1'b1;
                end
                if (sample_end || sample_req)
                    check("end_req_not_same_clk", {31'h0, sample_end && sample_req}, 32'd0);
                if (sample_end) begin
                    ends++;
                    if (exp_rx.size() == 0) begin
                        check("rx_queue_nonempty", 32'd0, 32'd1);
                    end else begin
                        logic [15:0] w;
                        w = exp_rx.pop_front();
                        check("audio_input_capture", {16'h0, audio_input}, {16'h0, w});
                    end
                end
                if (sample_req) begin
                    reqs++;
                    check("sample_req_at_bit63", tb_bit, 63);
                    check("sample_end_before_req", ends, 1);
                    if (first_req_pending) begin
                        first_req_pending = 1'b0;
                        // Counted from the first post-reset negedge, so 63 BCLK less one clk
                        check("first_req_latency", cyc - rel_cyc, 63 * 2 * BCLK_HALF - 1);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic finish_now();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_req && n < 2000);
        if (!sample_req) begin
            total++;
            $display("FAIL sample_req_timeout: no pulse within %0d clk expected one per frame", n);
            $display("%0d/%0d checks passed", passed, total);
            $fatal(1, "sample_req timeout");
        end
    endtask

    task automatic wait_bit(input int b);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tb_bit != b && n < 2000);
        if (tb_bit != b) begin
            total++;
            $display("FAIL bitcnt_timeout: bit %0d not reached, at %0d", b, tb_bit);
            $display("%0d/%0d checks passed", passed, total);
            $fatal(1, "bitcnt timeout");
        end
    endtask

    initial begin
        reset = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b0;

        // Frame 0 carries 0x0000; A5C3 goes into frame 1
        wait_req();
        audio_output = 16'hA5C3;
        exp_tx.push_back(16'hA5C3);
        // Mid-frame change must not disturb the frame in flight
        repeat (100) @(negedge clk);
        audio_output = 16'h1234;
        wait_req();
        exp_tx.push_back(16'h1234);
        wait_req();
        audio_output = 16'h0F0F;
        exp_tx.push_back(16'h0F0F);
        wait_req();
        audio_output = 16'h8000;
        exp_tx.push_back(16'h8000);

        // One-clk reset at bit 20: the frame after it must send 0x0000
        wait_bit(20);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_req();
        exp_tx.push_back(audio_output);

`ifdef AUDIO_LOOPBACK_EN
        wait_req();
        audio_output = 16'h7FFF;
        loopback = 1'b1;
        exp_tx.push_back(16'h7FFF);
        wait_req();
        loopback = 1'b0;
        exp_tx.push_back(audio_output);
`endif

        wait_req();
        exp_tx.push_back(audio_output);
        repeat (4 * BCLK_HALF) @(negedge clk);
        finish_now();
    end

endmodule
`default_nettype wire

// File: doc/audio_codec_link.md
AUDIO_CODEC_LINK -- requirements
Module: audio_codec_link

Interface
REQ-001 SHALL have parameter BCLK_HALF, default 4, meaning clk cycles per half period of AUD_BCLK (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the system clock; every register is clocked on its rising edge.
REQ-003 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port audio_output, input, 16, the signed DAC sample supplied by the effects path.
REQ-005 SHALL have port audio_input, output, 16, the signed ADC sample captured from the codec (left channel).
REQ-006 SHALL have port sample_req, output, 1, a one-clk pulse requesting that the next DAC sample be placed on audio_output.
REQ-007 SHALL have port sample_end, output, 1, a one-clk pulse marking audio_input as newly valid.
REQ-008 SHALL have port AUD_BCLK, output, 1, the codec bit clock.
REQ-009 SHALL have port AUD_DACLRCK, output, 1, the DAC word select (0 = left, 1 = right).
REQ-010 SHALL have port AUD_ADCLRCK, output, 1, the ADC word select, always identical to AUD_DACLRCK.
REQ-011 SHALL have port AUD_DACDAT, output, 1, the serial DAC data.
REQ-012 SHALL have port AUD_ADCDAT, input, 1, the serial ADC data.
REQ-013 SHALL have port loopback, input, 1, present only under AUDIO_LOOPBACK_EN (see REQ-029).

Function
REQ-014 SHALL divide clk by a counter 0..BCLK_HALF-1; AUD_BCLK SHALL toggle when the counter wraps, so period = 2*BCLK_HALF clk.
REQ-015 SHALL keep a 6-bit bit counter bitcnt 0..63 that advances on each AUD_BCLK falling edge and wraps 63->0; one frame = 64 BCLK = 128*BCLK_HALF clk (512 at default).
REQ-016 SHALL drive AUD_DACLRCK/AUD_ADCLRCK = 0 for bitcnt 0..31 and 1 for bitcnt 32..63, changing on the BCLK falling edge.
REQ-017 SHALL use I2S framing: per channel, the slot bit at offset 0 is 0, offsets 1..16 carry the sample MSB first, and offsets 17..31 are 0.
REQ-018 SHALL pulse sample_req for exactly one clk on the BCLK falling edge that enters bitcnt 63.
REQ-019 SHALL latch audio_output into a 16-bit tx register on the BCLK falling edge that enters bitcnt 0; the source then has 2*BCLK_HALF-1 clk after sample_req to update.
REQ-020 SHALL transmit the tx register in both the left and the right slots (mono duplicate); the tx register SHALL NOT change mid-frame.
REQ-021 SHALL change AUD_DACDAT only on BCLK falling edges and sample AUD_ADCDAT only on BCLK rising edges.
REQ-022 SHALL shift left-slot ADC bits at offsets 1..16 into a 16-bit rx shift register MSB first and ignore the right slot entirely.
REQ-023 SHALL, one clk after the rising edge that samples left offset 16, update audio_input with the full shift register and pulse sample_end for one clk in that same cycle.
REQ-024 SHALL assert sample_end and sample_req at most once per frame each and never in the same clk; sample_end SHALL precede sample_req within the frame.
REQ-025 SHALL hold audio_input stable between sample_end pulses.

Reset
REQ-026 SHALL, while reset is high, clear the divider counter, bitcnt, tx and rx registers and audio_input, and force AUD_BCLK, both LRCK outputs, AUD_DACDAT, sample_req and sample_end to 0.
REQ-027 SHALL, when reset asserts mid-frame, abort the frame in that clk; after reset deasserts it SHALL restart at bitcnt 0, and the first frame transmits 0x0000.
REQ-028 SHALL emit the first sample_req 63 BCLK periods after reset deasserts.

Configuration
REQ-029 SHALL support AUDIO_LOOPBACK_EN:
- Defined: the loopback port exists; when loopback = 1, the rx path samples the internal AUD_DACDAT value in place of AUD_ADCDAT, and AUD_DACDAT still drives the pin.
- Undefined: the loopback port and loopback mux are absent, and rx always uses AUD_ADCDAT.

Verification
REQ-030 Reset: reset held 10 clk, then released -> all outputs 0 during reset; AUD_BCLK period 8 clk; first sample_req at clk 8*63 (+/-1) after release.
REQ-031 TX: audio_output = 0xA5C3 applied at sample_req -> the next frame carries 0xA5C3 MSB first at left offsets 1..16 and right offsets 1..16, with 0 at every other bit.
REQ-032 RX: the codec model drives 0x8001 in the left slot and 0xFFFF in the right -> sample_end pulses once with audio_input = 0x8001.
REQ-033 Stability: audio_output changed to 0x1234 mid-frame -> the current frame is unaffected; 0x1234 goes out only after the next sample_req latch.
REQ-034 Mid-frame reset: reset pulsed 1 clk at bitcnt 20 -> bitcnt returns to 0, no sample_end in the aborted frame, and the next frame transmits 0x0000.
REQ-035 Loopback (AUDIO_LOOPBACK_EN defined, loopback = 1, audio_output = 0x7FFF, AUD_ADCDAT tied to 0) -> audio_input = 0x7FFF one frame later.
